btn_conditioner: RTL

//  NCH-channel push-button front end: 2-FF synchroniser, counter debouncer and registered edge pulser
//  per channel, with optional per-channel hold-to-auto-repeat. Sits between board buttons and the

---
 rtl/btn_cond_pkg.sv | 18 +
 rtl/btn_chan.sv | 134 +++++++++++++
 rtl/btn_conditioner.sv | 51 +++++
 3 files changed

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner.
//   rpt_state_t : per-channel auto-repeat FSM state encoding (2 bits)
//   cnt_width() : counter width needed to hold values 0..n-1 (minimum 1 bit)
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // button released
    ST_HOLD   = 2'd1,  // pressed, no auto-repeat
    ST_DELAY  = 2'd2,  // pressed, waiting for the first repeat
    ST_REPEAT = 2'd3   // pressed, repeating at the period rate
  } rpt_state_t;

  // Width of a counter that must reach n-1; never less than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, counter debouncer, and an
// auto-repeat FSM that produces registered 1-cycle press/release pulses.
// Ports:
//   clock         in  system clock, rising edge
//   reset         in  asynchronous active-low reset
//   btn           in  raw asynchronous button level (1 = pressed)
//   rpt_en        in  auto-repeat enable for this channel
//   deb_level     out debounced button level
//   press_pulse   out 1-cycle pulse on accepted press and on each repeat
//   release_pulse out 1-cycle pulse on accepted release
module btn_chan
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic rpt_en,
  output logic deb_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int DW      = cnt_width(DEB_CYCLES);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = cnt_width(RPT_MAX);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD - 1);

  logic [1:0]    sync_reg;
  logic          deb_level_reg;
  logic [DW-1:0] deb_cnt_reg;
  rpt_state_t    state_reg;
  logic [RW-1:0] rcnt_reg;
  logic          press_reg;
  logic          release_reg;

  logic s;
  assign s = sync_reg[1];

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn};
    end
  end

  // Debouncer: the level is accepted only after DEB_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_level_reg <= 1'b0;
      deb_cnt_reg   <= '0;
    end else if (s == deb_level_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg == DEB_LAST) begin
      deb_level_reg <= ~deb_level_reg;
      deb_cnt_reg   <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + DW'(1);
    end
  end

  // Repeat FSM. Edge detection falls out of the state: deb_level high while
  // IDLE is a fresh rise, deb_level low in any other state is a fresh fall.
  // A fall takes priority over a repeat due in the same cycle, and dropping
  // rpt_en takes priority over a due repeat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      rcnt_reg    <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          rcnt_reg <= '0;
          if (deb_level_reg) begin
            press_reg <= 1'b1;
            state_reg <= rpt_en ? ST_DELAY : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!deb_level_reg) begin
            release_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (!deb_level_reg) begin
            release_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else if (!rpt_en) begin
            state_reg <= ST_HOLD;
          end else if (rcnt_reg == DELAY_LAST) begin
            press_reg <= 1'b1;
            rcnt_reg  <= '0;
            state_reg <= ST_REPEAT;
          end else begin
            rcnt_reg <= rcnt_reg + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (!deb_level_reg) begin
            release_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else if (!rpt_en) begin
            state_reg <= ST_HOLD;
          end else if (rcnt_reg == PERIOD_LAST) begin
            press_reg <= 1'b1;
            rcnt_reg  <= '0;
          end else begin
            rcnt_reg <= rcnt_reg + RW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign deb_level     = deb_level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

endmodule

// File: rtl/btn_conditioner.sv
// NCH-channel push-button front end: each channel is synchronised,
// debounced, edge-detected and optionally auto-repeated independently.
// Ports:
//   clock         in  system clock, rising edge
//   reset         in  asynchronous active-low reset
//   btn_in        in  [NCH] raw button levels, 1 = pressed
//   rpt_en        in  [NCH] per-channel auto-repeat enable
//   deb_level     out [NCH] debounced levels
//   press_pulse   out [NCH] press / repeat pulses
//   release_pulse out [NCH] release pulses
//   any_press     out OR of press_pulse
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] btn_in,
  input  logic [NCH-1:0] rpt_en,
  output logic [NCH-1:0] deb_level,
  output logic [NCH-1:0] press_pulse,
  output logic [NCH-1:0] release_pulse,
  output logic           any_press
);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      btn_chan #(
        .DEB_CYCLES(DEB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
      ) u_chan (
        .clock        (clock),
        .reset        (reset),
        .btn          (btn_in[gi]),
        .rpt_en       (rpt_en[gi]),
        .deb_level    (deb_level[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi])
      );
    end
  endgenerate

  // Per-channel pulses are registered, so the OR stays a clean 1-cycle pulse.
  assign any_press = |press_pulse;

endmodule
